// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus unified-memory port of the load/store unit.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_w_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_w_en, mem_addr, mem_wdata
   );
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_w_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-master load/store path with alignment and range faults,
// load extension, and read-modify-write for sub-word stores.
module load_store_unit #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0003_FFFD
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   state_t      state_q, state_d;
   logic        write_q, write_d, signed_q, signed_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        mem_w_en_q, mem_w_en_d, rsp_fault_q, rsp_fault_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rsp_rdata_q, rsp_rdata_d;
   logic [32:0] end_addr;
   logic        fault, word_store;
   logic [31:0] load_val, merged;
   // last byte touched is checked in 33 bits so addresses near 2^32 cannot wrap past the limit
   assign end_addr   = {1'b0, bus.req_addr} + 33'd3;
   assign fault      = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) || (end_addr > {1'b0, ADDR_LIMIT});
   assign word_store = bus.req_write && bus.req_size == 2'b10;
   assign load_val   = size_q == 2'b00 ? {{24{signed_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]} :
                       size_q == 2'b01 ? {{16{signed_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]} : bus.mem_rdata;
   assign merged     = size_q == 2'b00 ? {bus.mem_rdata[31:8], wdata_q[7:0]} : {bus.mem_rdata[31:16], wdata_q[15:0]};
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      size_d      = size_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_w_en_d  = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_fault_d = rsp_fault_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            write_d     = bus.req_write;
            size_d      = bus.req_size;
            signed_d    = bus.req_signed;
            addr_d      = bus.req_addr;
            wdata_d     = bus.req_wdata;
            rsp_rdata_d = '0;
            rsp_fault_d = fault;
            mem_addr_d  = fault ? mem_addr_q : bus.req_addr;
            mem_wdata_d = (!fault && word_store) ? bus.req_wdata : mem_wdata_q;
            mem_w_en_d  = !fault && word_store;
            state_d     = fault ? RESP : word_store ? WRITE : READ;
         end
         READ: begin
            mem_wdata_d = write_q ? merged : mem_wdata_q;
            mem_w_en_d  = write_q;
            rsp_rdata_d = write_q ? '0 : load_val;
            state_d     = write_q ? WRITE : RESP;
         end
         WRITE: state_d = RESP;
         RESP: state_d = bus.rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_w_en_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_w_en_q  <= mem_w_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end
   assign bus.req_ready = state_q == IDLE;
   assign bus.rsp_valid = state_q == RESP;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign bus.mem_w_en  = mem_w_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule
